// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity stream generator.
package parity_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_e;

  // Packet framing state: either between packets or inside a multi-beat packet.
  typedef logic [0:0] pkt_state_t;
  localparam pkt_state_t ST_IDLE   = 1'b0;
  localparam pkt_state_t ST_IN_PKT = 1'b1;

  // Widest word the reduction helper handles; narrower words are zero-extended,
  // which leaves their parity unchanged.
  localparam int unsigned PAR_MAX_W = 1024;

  function automatic logic reduce_par(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/parity_stream_gen_accum.sv
// Packet parity accumulator: framing state, packet parity, saturating beat count
// and the parity mode latched at the first beat of each packet.
module parity_accum
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CNT_W       = 8,
  parameter bit          ODD_DEFAULT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic [DATA_W-1:0] data,
  input  logic              last,
  input  logic              odd_mode,
  output logic              beat_par,
  output logic              pkt_par,
  output logic [CNT_W-1:0]  pkt_beats
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  pkt_state_t        state_q, state_d;
  par_mode_e         mode_q;
  logic              acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              in_idle;
  logic              mode;
  logic              data_par;
  logic              acc_new;
  logic [CNT_W-1:0]  cnt_new;

  always_comb begin
    in_idle  = (state_q == ST_IDLE);
    mode     = in_idle ? odd_mode : (mode_q == PAR_ODD);
    data_par = reduce_par(PAR_MAX_W'(data));
    acc_new  = in_idle ? data_par : (acc_q ^ data_par);
    if (in_idle) begin
      cnt_new = CNT_W'(1);
    end else if (cnt_q == CntMax) begin
      cnt_new = cnt_q;
    end else begin
      cnt_new = cnt_q + CNT_W'(1);
    end
    state_d = last ? ST_IDLE : ST_IN_PKT;
  end

  assign beat_par  = data_par ^ mode;
  assign pkt_par   = acc_new ^ mode;
  assign pkt_beats = cnt_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= par_mode_e'(ODD_DEFAULT);
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= state_d;
      acc_q   <= acc_new;
      cnt_q   <= cnt_new;
      // Mode is latched only on a packet's first beat; later changes are ignored.
      if (in_idle) begin
        mode_q <= par_mode_e'(odd_mode);
      end
    end
  end

endmodule

// File: rtl/parity_stream_gen.sv
// Pipelined per-beat / per-packet parity generator on a valid/ready stream.
// Optional receive-parity checking is enabled by defining PARITY_STREAM_CHECK_EN.
module parity_stream_gen
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CNT_W       = 8,
  parameter bit          ODD_DEFAULT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
`ifdef PARITY_STREAM_CHECK_EN
  input  logic              s_par,
  output logic              m_err,
  output logic [15:0]       err_cnt,
`endif
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_beat_par,
  output logic              m_pkt_par,
  output logic [CNT_W-1:0]  m_pkt_beats
);

  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_last_q;
  logic              m_beat_par_q;
  logic              m_pkt_par_q;
  logic [CNT_W-1:0]  m_pkt_beats_q;

  logic              accept;
  logic              beat_par;
  logic              pkt_par;
  logic [CNT_W-1:0]  pkt_beats;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;

  parity_accum #(
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .ODD_DEFAULT (ODD_DEFAULT)
  ) u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .data      (s_data),
    .last      (s_last),
    .odd_mode  (odd_mode),
    .beat_par  (beat_par),
    .pkt_par   (pkt_par),
    .pkt_beats (pkt_beats)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      m_beat_par_q  <= 1'b0;
      m_pkt_par_q   <= 1'b0;
      m_pkt_beats_q <= '0;
    end else if (accept) begin
      m_valid_q     <= 1'b1;
      m_data_q      <= s_data;
      m_last_q      <= s_last;
      m_beat_par_q  <= beat_par;
      m_pkt_par_q   <= pkt_par;
      m_pkt_beats_q <= pkt_beats;
    end else if (m_ready) begin
      m_valid_q     <= 1'b0;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign m_beat_par  = m_beat_par_q;
  assign m_pkt_par   = m_pkt_par_q;
  assign m_pkt_beats = m_pkt_beats_q;

`ifdef PARITY_STREAM_CHECK_EN
  logic        m_err_q;
  logic [15:0] err_cnt_q;
  logic        beat_err;

  assign beat_err = (s_par != beat_par);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (accept) begin
      m_err_q <= beat_err;
      if (beat_err && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign m_err   = m_err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_stream_gen.sv
// Self-checking bench for parity_stream_gen: directed cases plus randomized traffic
// against a packet-level reference model.
module tb_parity_stream_gen;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              odd_mode;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_beat_par;
  logic              m_pkt_par;
  logic [CNT_W-1:0]  m_pkt_beats;
`ifdef PARITY_STREAM_CHECK_EN
  logic              s_par;
  logic              m_err;
  logic [15:0]       err_cnt;
`endif

  parity_stream_gen #(
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .ODD_DEFAULT (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .odd_mode    (odd_mode),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
`ifdef PARITY_STREAM_CHECK_EN
    .s_par       (s_par),
    .m_err       (m_err),
    .err_cnt     (err_cnt),
`endif
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_beat_par  (m_beat_par),
    .m_pkt_par   (m_pkt_par),
    .m_pkt_beats (m_pkt_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected output register contents and the open packet's beats.
  bit       exp_valid;
  bit [7:0] exp_data;
  bit       exp_last;
  bit       exp_bpar;
  bit       exp_ppar;
  int       exp_beats;
  bit       pkt_open;
  bit       pkt_mode;
  bit       pkt_bits[$];
  int       exp_errcnt;
  bit       exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_valid  = 1'b0;
    exp_data   = '0;
    exp_last   = 1'b0;
    exp_bpar   = 1'b0;
    exp_ppar   = 1'b0;
    exp_beats  = 0;
    pkt_open   = 1'b0;
    pkt_mode   = 1'b0;
    pkt_bits.delete();
    exp_errcnt = 0;
    exp_err    = 1'b0;
  endtask

  // Applied at each rising edge with the inputs that were present there.
  task automatic model_update();
    bit accept;
    bit bp;
    bit acc;
    accept = rst_n && s_valid && (!exp_valid || m_ready);
    if (accept) begin
      if (!pkt_open) begin
        pkt_mode = odd_mode;
        pkt_bits.delete();
      end
      bp = 1'b0;
      for (int i = 0; i < DATA_W; i++) bp ^= s_data[i];
      pkt_bits.push_back(bp);
      acc = 1'b0;
      foreach (pkt_bits[i]) acc ^= pkt_bits[i];
      exp_bpar  = bp ^ pkt_mode;
      exp_ppar  = acc ^ pkt_mode;
      exp_beats = (pkt_bits.size() > CNT_MAX) ? CNT_MAX : pkt_bits.size();
      exp_data  = s_data;
      exp_last  = s_last;
      exp_valid = 1'b1;
      pkt_open  = !s_last;
`ifdef PARITY_STREAM_CHECK_EN
      exp_err = (s_par != exp_bpar);
      if (exp_err && exp_errcnt < 16'hFFFF) exp_errcnt++;
`endif
    end else if (m_ready) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    check("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("m_data", 32'(m_data), 32'(exp_data));
      check("m_last", 32'(m_last), 32'(exp_last));
      check("m_beat_par", 32'(m_beat_par), 32'(exp_bpar));
      check("m_pkt_par", 32'(m_pkt_par), 32'(exp_ppar));
      check("m_pkt_beats", 32'(m_pkt_beats), 32'(exp_beats));
`ifdef PARITY_STREAM_CHECK_EN
      check("m_err", 32'(m_err), 32'(exp_err));
`endif
    end
`ifdef PARITY_STREAM_CHECK_EN
    check("err_cnt", 32'(err_cnt), 32'(exp_errcnt));
`endif
  endtask

  // Inputs are driven just after a falling edge; this runs one full clock.
  task automatic cycle();
    #1;
    check("s_ready", 32'(s_ready), 32'(!exp_valid || m_ready));
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic drive(input bit v, input bit [7:0] d, input bit l, input bit odd,
                       input bit rdy);
    s_valid  = v;
    s_data   = d;
    s_last   = l;
    odd_mode = odd;
    m_ready  = rdy;
  endtask

  task automatic beat(input string tag, input bit [7:0] d, input bit l, input bit odd,
                      input bit bpar, input bit ppar, input int beats);
    drive(1'b1, d, l, odd, 1'b1);
    cycle();
    check({tag, ".valid"}, 32'(m_valid), 32'd1);
    check({tag, ".beat_par"}, 32'(m_beat_par), 32'(bpar));
    check({tag, ".pkt_par"}, 32'(m_pkt_par), 32'(ppar));
    check({tag, ".beats"}, 32'(m_pkt_beats), 32'(beats));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".m_valid"}, 32'(m_valid), 32'd0);
    check({tag, ".m_data"}, 32'(m_data), 32'd0);
    check({tag, ".m_last"}, 32'(m_last), 32'd0);
    check({tag, ".m_beat_par"}, 32'(m_beat_par), 32'd0);
    check({tag, ".m_pkt_par"}, 32'(m_pkt_par), 32'd0);
    check({tag, ".m_pkt_beats"}, 32'(m_pkt_beats), 32'd0);
    check({tag, ".s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef PARITY_STREAM_CHECK_EN
    s_par = 1'b0;
`endif
    model_reset();
    #2;
    check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Even mode, single-beat packets.
    beat("sb00", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    beat("sb01", 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    beat("sbFF", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    beat("sb5A", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    // Odd mode, three-beat packet.
    beat("odd1", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    beat("odd2", 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    beat("odd3", 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 3);

    // Backpressure: held output, no loss or duplication.
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
      cycle();
      check("stall.s_ready", 32'(s_ready), 32'd0);
      check("stall.m_data", 32'(m_data), 32'h11);
    end
    drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
    cycle();
    check("release.m_data", 32'(m_data), 32'h22);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle();
    check("drain.m_valid", 32'(m_valid), 32'd0);

    // Saturating count with CNT_W=2: six beats of 0x01, even.
    beat("sat1", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    beat("sat2", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    beat("sat3", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    beat("sat4", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    beat("sat5", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 3);
    beat("sat6", 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 3);

    // odd_mode changed mid-packet is ignored until the next packet.
    beat("tog1", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    beat("tog2", 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 2);
    beat("tog3", 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 3);
    beat("tog4", 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 3);
    beat("tognext", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1);

    // Asynchronous reset after beat 2 of 4, with the output stalled.
    beat("rst1", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    beat("fresh1", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    beat("fresh2", 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 2);

`ifdef PARITY_STREAM_CHECK_EN
    s_par = 1'b1;
    beat("chk1", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    check("chk1.m_err", 32'(m_err), 32'd1);
    beat("chk2", 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    check("chk2.m_err", 32'(m_err), 32'd0);
    check("chk2.err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0,
            1'($urandom), $urandom_range(0, 9) < 7);
`ifdef PARITY_STREAM_CHECK_EN
      s_par = 1'($urandom);
`endif
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_stream_gen.md
Name: parity_stream_gen

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational parity generator.
- Computes per-beat parity over a DATA_W-bit valid/ready stream.
- Accumulates packet parity and beat count across multi-beat packets delimited by s_last, with even/odd selectable per packet.
- Sits between a data source and a link/storage stage that appends parity to each word and packet.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- CNT_W, 8, width of packet beat counter; saturates at 2^CNT_W-1.
- ODD_DEFAULT, 0, parity mode used when odd_mode is not driven (tie-off value for odd_mode).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- odd_mode  in  1  1=odd parity, 0=even; sampled on first beat of each packet.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&&s_ready.
- s_data  in  DATA_W  input word.
- s_last  in  1  final beat of packet.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  registered copy of s_data.
- m_last  out  1  registered copy of s_last.
- m_beat_par  out  1  parity bit of this beat (^data, XOR 1 if odd).
- m_pkt_par  out  1  running packet parity including this beat (XOR 1 if odd); final value is valid when m_last=1.
- m_pkt_beats  out  CNT_W  beats in packet so far including this beat, saturating.

Behaviour:
- Single register stage; latency is exactly 1 cycle from accept to m_valid.
- s_ready = !m_valid || m_ready, combinational with no other gating; full throughput at 1 beat/cycle under continuous m_ready.
- m_* holds stable while m_valid && !m_ready (AXI-style); m_valid drops after the handshake if no new beat is accepted.
- FSM states:
  - IDLE: no packet open. Accepting a beat samples odd_mode into mode_q, seeds acc = ^s_data and cnt = 1. Go to IN_PKT unless s_last, in which case stay in IDLE.
  - IN_PKT: each accepted beat updates acc ^= ^s_data and cnt = sat(cnt+1). s_last returns to IDLE.
- Output computation: m_pkt_par = acc_new ^ mode; m_beat_par = ^s_data ^ mode (mode = odd_mode in IDLE, else mode_q).
- Changes to odd_mode mid-packet are ignored.
- Single-beat packet: m_pkt_par == m_beat_par and m_pkt_beats = 1.
- Count saturates at 2^CNT_W-1 and never wraps; parity accumulation continues correctly after saturation.
- Reset (any time, including mid-packet or mid-stall): m_valid=0, m_data=0, m_last=0, m_beat_par=0, m_pkt_par=0, m_pkt_beats=0, FSM=IDLE, acc=0, mode_q=0. A partially accepted packet is discarded. s_ready=1 while in reset.
- No accept occurs while rst_n=0.

Optional Feature:
- Macro PARITY_STREAM_CHECK_EN.
- When defined:
  - Adds input s_par (1 bit, the parity received with the beat), output m_err (1 bit, registered with the beat, = s_par != computed beat parity), and output err_cnt (16 bits).
  - err_cnt increments on each accepted beat with a mismatch, saturates at 0xFFFF, and is cleared only by reset.
- When undefined: these ports and that logic do not exist; behaviour is otherwise identical.

Decomposition:
- Package parity_pkg: parity mode enum (PAR_EVEN=0, PAR_ODD=1), FSM state enum (ST_IDLE, ST_IN_PKT), and a reduction-parity function (DATA_W-generic).
- One natural sub-module, parity_accum: holds acc, cnt and mode_q, with the saturating counter. The top holds the handshake register stage.

Test Plan:
- Even mode, DATA_W=8, single-beat packets 0x00, 0x01, 0xFF, 0x5A with s_last=1 -> m_beat_par = 0, 1, 0, 0; m_pkt_par equal to m_beat_par; m_pkt_beats=1; latency 1.
- Odd mode, 3-beat packet 0x01, 0x03, 0x07 -> m_beat_par = 0, 1, 0; m_pkt_par = 0, 0, 1 (XOR of 1, 0, 1 is 0, inverted gives 1 on the last beat); m_pkt_beats = 1, 2, 3.
- m_ready=0 for 4 cycles while m_valid=1 -> s_ready=0 and all m_* held stable; release m_ready -> next beat accepted the same cycle, no loss or duplication.
- CNT_W=2, 6-beat packet of 0x01 -> m_pkt_beats = 1, 2, 3, 3, 3, 3; final m_pkt_par = 0 (even, 6 ones).
- odd_mode toggled on beat 2 of a packet -> ignored until the next packet's first beat. Assert rst_n=0 after beat 2 of 4 -> m_valid=0 asynchronously; next packet starts fresh with m_pkt_beats=1.
- With PARITY_STREAM_CHECK_EN, even mode: beats 0x03 with s_par=1 and 0x01 with s_par=1 -> m_err = 1, 0; err_cnt=1.
